// File: rtl/summ_sa_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : summ_sa_ctrl
//  Description : Per-focal-point sequencer for the summ_sa accumulator: clears,
//                streams NUM_CHANNELS samples, latches and hands off each sum.
//  Revision    : 1.0 - initial release
// ============================================================================
module summ_sa_ctrl #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int SUM_WIDTH    = DATA_WIDTH + $clog2(NUM_CHANNELS),
    parameter int POINT_WIDTH  = 12,
    parameter int TIMEOUT      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic [POINT_WIDTH-1:0] num_points,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   in_ready,
    output logic                   start_sum,
    output logic                   sum_en,
    output logic [DATA_WIDTH-1:0]  delayed_sample,
    output logic                   done_channel,
    input  logic [SUM_WIDTH-1:0]   sum_result,
    input  logic                   sum_valid,
    output logic                   out_valid,
    output logic [SUM_WIDTH-1:0]   out_data,
    output logic [POINT_WIDTH-1:0] out_index,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   timeout_err
);

    localparam int c_CH_W = $clog2(NUM_CHANNELS);
    localparam int c_TO_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CH_W-1:0]      c_LAST_CH = c_CH_W'(NUM_CHANNELS - 1);
    localparam logic [c_TO_W-1:0]      c_TO_LAST = c_TO_W'(TIMEOUT - 1);
    localparam logic [POINT_WIDTH-1:0] c_ONE_PT  = POINT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_ACCUM  = 3'd2,
        S_LATCH  = 3'd3,
        S_WAIT   = 3'd4,
        S_OUTPUT = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                 r_state;
    logic [POINT_WIDTH-1:0] r_num_points;
    logic [c_CH_W-1:0]      r_chan_cnt;
    logic [c_TO_W-1:0]      r_wait_cnt;
    logic [SUM_WIDTH-1:0]   r_out_data;
    logic [POINT_WIDTH-1:0] r_out_index;
    logic                   r_in_ready;
    logic                   r_start_sum;
    logic                   r_done_channel;
    logic                   r_out_valid;
    logic                   r_busy;
    logic                   r_frame_done;
    logic                   r_timeout_err;
    logic                   w_accept;

    // The sample path is combinational so an offered sample is summed in the
    // same cycle it is accepted.
    assign w_accept       = r_in_ready & in_valid;
    assign sum_en         = w_accept;
    assign delayed_sample = w_accept ? in_data : '0;

    assign in_ready     = r_in_ready;
    assign start_sum    = r_start_sum;
    assign done_channel = r_done_channel;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_index    = r_out_index;
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;
    assign timeout_err  = r_timeout_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_num_points   <= '0;
            r_chan_cnt     <= '0;
            r_wait_cnt     <= '0;
            r_out_data     <= '0;
            r_out_index    <= '0;
            r_in_ready     <= 1'b0;
            r_start_sum    <= 1'b0;
            r_done_channel <= 1'b0;
            r_out_valid    <= 1'b0;
            r_busy         <= 1'b0;
            r_frame_done   <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_start_sum    <= 1'b0;
            r_done_channel <= 1'b0;
            r_frame_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_num_points  <= num_points;
                        r_timeout_err <= 1'b0;
                        r_busy        <= 1'b1;
                        if (num_points == '0) begin
                            r_frame_done <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_start_sum <= 1'b1;
                            r_state     <= S_START;
                        end
                    end
                end
                S_START: begin
                    r_chan_cnt <= '0;
                    r_in_ready <= 1'b1;
                    r_state    <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        if (r_chan_cnt == c_LAST_CH) begin
                            r_in_ready     <= 1'b0;
                            r_done_channel <= 1'b1;
                            r_state        <= S_LATCH;
                        end else begin
                            r_chan_cnt <= r_chan_cnt + 1'b1;
                        end
                    end
                end
                S_LATCH: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (sum_valid) begin
                        r_out_data  <= sum_result;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUTPUT;
                    end else if (r_wait_cnt == c_TO_LAST) begin
                        // Accumulator never answered: abandon the frame.
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_out_index == r_num_points - c_ONE_PT) begin
                            r_frame_done <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_out_index <= r_out_index + c_ONE_PT;
                            r_start_sum <= 1'b1;
                            r_state     <= S_START;
                        end
                    end
                end
                S_DONE: begin
                    r_out_index <= '0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
